// File: rtl/btb_access_scheduler_pkg.sv
// btb_access_scheduler_pkg: shared FSM state and update-entry types
package btb_access_scheduler_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, PEND = 2'b01, FORCE = 2'b10} sched_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
  } upd_entry_t;
endpackage

// File: rtl/btb_upd_fifo.sv
// btb_upd_fifo: circular queue of resolved-branch updates with occupancy count
module btb_upd_fifo import btb_access_scheduler_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic                    pop,
  input  upd_entry_t              din,
  output upd_entry_t              head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);
  localparam int AW = $clog2(DEPTH);
  upd_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head  = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  // Entries are discarded on reset by clearing the count; storage needs no reset
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/btb_access_scheduler.sv
// btb_access_scheduler: arbitrates the shared BTB index port between fetch lookups and queued updates.
// Optional BTB_SCHED_STATS_EN adds saturating stat_forced / stat_stalls counters.
module btb_access_scheduler import btb_access_scheduler_pkg::*; #(
  parameter int QUEUE_DEPTH  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          fetch_req,
  input  logic [31:0]                   fetch_pc,
  input  logic                          upd_valid,
  input  logic [31:0]                   upd_pc,
  input  logic [31:0]                   upd_target,
  output logic                          upd_ready,
  output logic                          btb_access,
  output logic                          btb_update,
  output logic [31:0]                   btb_lookup_pc,
  output logic [31:0]                   btb_upd_pc,
  output logic [31:0]                   btb_upd_target,
  output logic                          fetch_stall,
  output logic [$clog2(QUEUE_DEPTH):0]  q_count
`ifdef BTB_SCHED_STATS_EN
  ,
  output logic [15:0]                   stat_forced,
  output logic [15:0]                   stat_stalls
`endif
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  sched_state_t state;
  logic [7:0] starve;
  logic run, push, pop, full, empty, lim;
  logic [CW-1:0] next_cnt;
  upd_entry_t din, head;
  assign din       = '{pc: upd_pc, target: upd_target};
  // run holds upd_ready low until the first edge after reset release
  assign upd_ready = run && !full;
  assign push      = upd_valid && upd_ready;
  always_comb begin
    btb_access    = reset_n && fetch_req && state != FORCE;
    btb_update    = state == FORCE || (state == PEND && !fetch_req);
    fetch_stall   = state == FORCE && fetch_req;
    btb_lookup_pc = reset_n ? fetch_pc : '0;
  end
  assign pop            = btb_update;
  assign btb_upd_pc     = head.pc;
  assign btb_upd_target = head.target;
  assign next_cnt       = q_count + CW'(push) - CW'(pop);
  assign lim            = starve == 8'(STARVE_LIMIT - 1);
  btb_upd_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .din(din),
    .head(head), .count(q_count), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state  <= IDLE;
      starve <= '0;
      run    <= 1'b0;
    end else begin
      run    <= 1'b1;
      starve <= (state == PEND && !pop && !lim) ? starve + 8'd1 : '0;
      state  <= state == IDLE ? (push ? PEND : IDLE) :
                pop ? (next_cnt != '0 ? PEND : IDLE) :
                lim ? FORCE : PEND;
    end
`ifdef BTB_SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stat_forced <= '0;
      stat_stalls <= '0;
    end else begin
      stat_forced <= (state == FORCE && !(&stat_forced)) ? stat_forced + 16'd1 : stat_forced;
      stat_stalls <= (fetch_stall && !(&stat_stalls)) ? stat_stalls + 16'd1 : stat_stalls;
    end
`endif
endmodule
